cnn_frame_sequencer: RTL and testbench
======================================

Name: cnn_frame_sequencer

Overview:
- Front-end controller for the MNIST CNN pipeline (conv1 → maxpool1 → conv2 → maxpool2 → fc → comparator).
- Accepts one 28x28 binary image as a serial bit stream and frames it into pixel_valid beats with row/col/sof/eof markers for conv_layer_1.
- Flushes the line buffers with zero padding after the image, then waits for the classifier result.
- Returns the result through a valid/ready handshake and blocks new frames until that result is consumed.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame.
- FLUSH_CYCLES, 64, zero beats driven after the last pixel to drain conv/pool line buffers.
- TIMEOUT_CYCLES, 4096, max cycles in WAIT_RESULT (only used with TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle frame start request, honoured only in IDLE.
- data_in  in  1  serial pixel bit.
- data_in_valid  in  1  data_in qualifier.
- ready  out  1  high in IDLE only.
- pixel_out  out  1  registered pixel to conv_layer_1.
- pixel_valid  out  1  pixel_out qualifier.
- row  out  clog2(IMG_H)  row index of current beat.
- col  out  clog2(IMG_W)  column index of current beat.
- sof  out  1  with the first pixel of a frame.
- eof  out  1  with the last image pixel (IMG_H-1, IMG_W-1).
- pipe_clear  out  1  one-cycle pulse clearing downstream state at frame start.
- pipe_flush  out  1  high during FLUSH.
- fc_valid_in  in  1  classifier result strobe.
- fc_class_in  in  4  classifier result.
- prediction  out  4  latched class.
- valid_out  out  1  prediction valid.
- out_ready  in  1  consumer accepts prediction.
- timeout_err  out  1  result was forced by watchdog (0 without TIMEOUT_EN).

Behaviour:
- Reset:
  - FSM goes to IDLE and all counters clear.
  - pixel_out, pixel_valid, sof, eof, pipe_clear, pipe_flush, valid_out and timeout_err are 0; prediction is 4'h0; row and col are 0; ready is 1.
  - A reset during any state aborts the frame immediately, with no flush and no valid_out.
- FSM states: IDLE, LOAD, FLUSH, WAIT_RESULT, DONE.
- IDLE:
  - start=1 → LOAD.
  - pipe_clear pulses in the same transition cycle (registered, visible the next cycle).
  - Pixel counters are zeroed.
- LOAD:
  - Each cycle with data_in_valid=1, next cycle shows pixel_out=data_in, pixel_valid=1 and the current row/col. Latency is 1 cycle.
  - col increments, wrapping from IMG_W-1 to 0, and row increments on that wrap.
  - sof is asserted with beat (0,0); eof is asserted with beat (IMG_H-1, IMG_W-1).
  - data_in_valid=0 inserts a bubble: pixel_valid=0 and counters hold.
  - After the IMG_W*IMG_H-th accepted bit → FLUSH. Further data_in_valid in that cycle or later is ignored.
- FLUSH:
  - pipe_flush=1, pixel_valid=1, pixel_out=0, sof=eof=0 for exactly FLUSH_CYCLES beats.
  - row/col hold at (IMG_H-1, IMG_W-1).
  - Then → WAIT_RESULT.
- WAIT_RESULT:
  - On fc_valid_in=1, latch prediction = fc_class_in and go to DONE.
  - fc_class_in > 9 is saturated to 9.
  - fc_valid_in is ignored in all other states.
  - A strobe arriving during FLUSH is dropped; the bench must not rely on it.
- DONE:
  - valid_out=1 with prediction stable.
  - On valid_out & out_ready: valid_out deasserts next cycle → IDLE.
  - start during DONE is ignored (ready=0).
- A start asserted in the same cycle that DONE→IDLE completes is ignored. start is only sampled while the FSM is in IDLE.
- Counter widths are clog2 of the respective parameter. The flush/timeout counter is sized to max(FLUSH_CYCLES, TIMEOUT_CYCLES). No counter ever wraps past its terminal value.

Optional Feature:
- Macro: CNN_SEQ_TIMEOUT_EN.
- Defined:
  - WAIT_RESULT counts cycles.
  - If TIMEOUT_CYCLES elapse without fc_valid_in → DONE with prediction=4'hF and timeout_err=1.
  - timeout_err clears when the handshake completes.
- Undefined:
  - No counter is built and WAIT_RESULT waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Nominal frame: rst pulse, start, 784 contiguous valid bits (checkerboard) → pixel_out mirrors the stream at +1 cycle; sof on beat 0; eof on beat 783 at row=27 col=27; exactly 64 flush beats of 0; fc_valid_in with class 7 → valid_out=1, prediction=7 until out_ready.
- Bubbles: data_in_valid toggling 1/0 over a frame → pixel_valid counts exactly 784 before flush; col wraps 27→0 while row increments; no row/col change on bubble cycles.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE and pulse start → prediction is stable, ready=0, start is ignored; out_ready=1 → IDLE; the next start is accepted.
- Saturation/stray strobes: fc_valid_in during LOAD → ignored; fc_class_in=12 in WAIT_RESULT → prediction=9.
- Async reset mid-LOAD (pixel 300) → all outputs at reset values within the same cycle; a new frame then runs cleanly from sof.
- With CNN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: no fc_valid_in → after 16 cycles valid_out=1, prediction=4'hF, timeout_err=1; both clear after the handshake.

Source files
------------

// File: rtl/cnn_frame_sequencer_if.sv
// Frame-sequencer bus: serial pixel input, framed pixel output, classifier result handshake.
// Latency: none, wiring only.
// Backpressure: valid_out/out_ready on the result side; the pixel side has no backpressure.
interface cnn_frame_sequencer_if #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic          start;
    logic          data_in;
    logic          data_in_valid;
    logic          ready;
    logic          pixel_out;
    logic          pixel_valid;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          sof;
    logic          eof;
    logic          pipe_clear;
    logic          pipe_flush;
    logic          fc_valid_in;
    logic [3:0]    fc_class_in;
    logic [3:0]    prediction;
    logic          valid_out;
    logic          out_ready;
    logic          timeout_err;

    // Sequencer side
    modport master (
        input  start, data_in, data_in_valid, fc_valid_in, fc_class_in, out_ready,
        output ready, pixel_out, pixel_valid, row, col, sof, eof,
               pipe_clear, pipe_flush, prediction, valid_out, timeout_err
    );

    // Environment side (image source, CNN pipeline, result consumer)
    modport slave (
        output start, data_in, data_in_valid, fc_valid_in, fc_class_in, out_ready,
        input  ready, pixel_out, pixel_valid, row, col, sof, eof,
               pipe_clear, pipe_flush, prediction, valid_out, timeout_err
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frames a serial binary image into row/col beats, flushes the CNN line buffers, returns the class.
// Latency: 1 cycle data_in -> pixel_out; optional watchdog in WAIT_RESULT via CNN_SEQ_TIMEOUT_EN.
// Backpressure: result held in DONE until out_ready; no new frame accepted until it is consumed.
module cnn_frame_sequencer #(
    parameter int IMG_W          = 28,
    parameter int IMG_H          = 28,
    parameter int FLUSH_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    cnn_frame_sequencer_if.master      bus
);
    localparam int RW      = $clog2(IMG_H);
    localparam int CW      = $clog2(IMG_W);
    localparam int CNT_MAX = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, WAIT_RESULT, DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_cnt_q, row_cnt_d;   // position of the next pixel to accept
    logic [CW-1:0]    col_cnt_q, col_cnt_d;
    logic [RW-1:0]    row_q, row_d;           // position of the beat currently presented
    logic [CW-1:0]    col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;           // flush beats, then wait cycles
    logic             pixel_q, pixel_d;
    logic             pix_vld_q, pix_vld_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             clear_q, clear_d;
    logic             flush_q, flush_d;
    logic [3:0]       pred_q, pred_d;
    logic             vout_q, vout_d;
`ifdef CNN_SEQ_TIMEOUT_EN
    logic             tmo_q, tmo_d;
`endif

    logic last_pix;
    assign last_pix = (row_cnt_q == RW'(IMG_H - 1)) && (col_cnt_q == CW'(IMG_W - 1));

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        pixel_d   = 1'b0;
        pix_vld_d = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        clear_d   = 1'b0;
        flush_d   = 1'b0;
        pred_d    = pred_q;
        vout_d    = vout_q;
`ifdef CNN_SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                row_cnt_d = '0;
                col_cnt_d = '0;
                if (bus.start) begin
                    state_d = LOAD;
                    clear_d = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                if (bus.data_in_valid) begin
                    pixel_d   = bus.data_in;
                    pix_vld_d = 1'b1;
                    row_d     = row_cnt_q;
                    col_d     = col_cnt_q;
                    sof_d     = (row_cnt_q == '0) && (col_cnt_q == '0);
                    eof_d     = last_pix;
                    if (last_pix) begin
                        // Counters stay parked on the final pixel rather than wrapping.
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else if (col_cnt_q == CW'(IMG_W - 1)) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + 1'b1;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Zero beats at the last coordinate push the tail of the image through the line buffers.
                pix_vld_d = 1'b1;
                flush_d   = 1'b1;
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = WAIT_RESULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RESULT: begin
                if (bus.fc_valid_in) begin
                    pred_d  = (bus.fc_class_in > 4'd9) ? 4'd9 : bus.fc_class_in;
                    vout_d  = 1'b1;
                    state_d = DONE;
                end
`ifdef CNN_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    pred_d  = 4'hF;
                    vout_d  = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (vout_q && bus.out_ready) begin
                    vout_d  = 1'b0;
                    state_d = IDLE;
`ifdef CNN_SEQ_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            pixel_q   <= 1'b0;
            pix_vld_q <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            clear_q   <= 1'b0;
            flush_q   <= 1'b0;
            pred_q    <= 4'h0;
            vout_q    <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            pixel_q   <= pixel_d;
            pix_vld_q <= pix_vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            clear_q   <= clear_d;
            flush_q   <= flush_d;
            pred_q    <= pred_d;
            vout_q    <= vout_d;
`ifdef CNN_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.pixel_out   = pixel_q;
    assign bus.pixel_valid = pix_vld_q;
    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.sof         = sof_q;
    assign bus.eof         = eof_q;
    assign bus.pipe_clear  = clear_q;
    assign bus.pipe_flush  = flush_q;
    assign bus.prediction  = pred_q;
    assign bus.valid_out   = vout_q;
`ifdef CNN_SEQ_TIMEOUT_EN
    assign bus.timeout_err = tmo_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
module tb_cnn_frame_sequencer;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int FL   = 64;
    localparam int TMO  = 16;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_frame_sequencer_if #(.IMG_W(W), .IMG_H(H)) bus ();

    cnn_frame_sequencer #(
        .IMG_W(W), .IMG_H(H), .FLUSH_CYCLES(FL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       pix;
        logic [4:0] row;
        logic [4:0] col;
        logic       sof;
        logic       eof;
        logic       flush;
    } beat_t;

    typedef struct packed {
        logic [3:0] pred;
        logic       tmo;
    } res_t;

    beat_t exp_q[$];
    res_t  res_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every presented beat / accepted result pops one expectation.
    beat_t mon_act, mon_exp;
    res_t  res_act, res_exp;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_valid) begin
                mon_act = {bus.pixel_out, bus.row, bus.col, bus.sof, bus.eof, bus.pipe_flush};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=no_beat", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", mon_act, mon_exp);
                end
            end
            if (bus.valid_out && bus.out_ready) begin
                res_act = {bus.prediction, bus.timeout_err};
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=no_result", res_act);
                end else begin
                    res_exp = res_q.pop_front();
                    check("result", res_act, res_exp);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},       bus.ready,       1);
        check({tag, "_pixel_valid"}, bus.pixel_valid, 0);
        check({tag, "_pixel_out"},   bus.pixel_out,   0);
        check({tag, "_rowcol"},      {bus.row, bus.col}, 0);
        check({tag, "_sof_eof"},     {bus.sof, bus.eof}, 0);
        check({tag, "_clr_flush"},   {bus.pipe_clear, bus.pipe_flush}, 0);
        check({tag, "_valid_out"},   bus.valid_out,   0);
        check({tag, "_prediction"},  bus.prediction,  0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    task automatic start_frame;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("pipe_clear_pulse", bus.pipe_clear, 1);
        check("ready_low_in_load", bus.ready, 0);
    endtask

    // Feed n pixels; pattern 0 = checkerboard, 1 = every third pixel set.
    task automatic feed(input int n, input bit bubbles, input int pattern, input int stray_at);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            if (bubbles && i > 0) begin
                bus.data_in_valid = 1'b0;
                bus.data_in       = 1'b1;
                bus.fc_valid_in   = 1'b0;
                tick();
            end
            e.row   = 5'(i / W);
            e.col   = 5'(i % W);
            e.pix   = (pattern == 0) ? (((i / W) + (i % W)) % 2 == 1) : (i % 3 == 0);
            e.sof   = (i == 0);
            e.eof   = (i == NPIX - 1);
            e.flush = 1'b0;
            exp_q.push_back(e);
            bus.data_in       = e.pix;
            bus.data_in_valid = 1'b1;
            bus.fc_valid_in   = (i == stray_at);
            bus.fc_class_in   = 4'd3;
            tick();
        end
        bus.fc_valid_in = 1'b0;
        if (n == NPIX) begin
            for (int k = 0; k < FL; k++) begin
                e = '{pix: 1'b0, row: 5'(H - 1), col: 5'(W - 1), sof: 1'b0, eof: 1'b0, flush: 1'b1};
                exp_q.push_back(e);
            end
            // Surplus valid ones after the last pixel must not reach pixel_out.
            bus.data_in       = 1'b1;
            bus.data_in_valid = 1'b1;
            repeat (3) tick();
        end
        bus.data_in_valid = 1'b0;
        bus.data_in       = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic give_result(input logic [3:0] cls, input logic [3:0] req);
        res_t r;
        r.pred = req;
        r.tmo  = 1'b0;
        res_q.push_back(r);
        bus.fc_valid_in = 1'b1;
        bus.fc_class_in = cls;
        tick();
        bus.fc_valid_in = 1'b0;
        check("valid_out_rise", bus.valid_out, 1);
        check("prediction_latched", bus.prediction, req);
    endtask

    task automatic handshake(input bit with_start);
        bus.out_ready = 1'b1;
        bus.start     = with_start;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("valid_out_cleared", bus.valid_out, 0);
        check("ready_after_handshake", bus.ready, 1);
        check("timeout_err_cleared", bus.timeout_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.start         = 1'b0;
        bus.data_in       = 1'b0;
        bus.data_in_valid = 1'b0;
        bus.fc_valid_in   = 1'b0;
        bus.fc_class_in   = 4'd0;
        bus.out_ready     = 1'b0;
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Nominal checkerboard frame, class 7
        start_frame();
        feed(NPIX, 1'b0, 0, -1);
        drain("frame1_drain");
        repeat (5) tick();
        check("wait_holds_without_strobe", bus.valid_out, 0);
        give_result(4'd7, 4'd7);
        handshake(1'b0);

        // Bubbled frame, stray strobe in LOAD, saturated class, held result
        start_frame();
        feed(NPIX, 1'b1, 1, 100);
        drain("frame2_drain");
        give_result(4'd12, 4'd9);
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 10);
            tick();
            check("bp_valid_out", bus.valid_out, 1);
            check("bp_prediction", bus.prediction, 9);
            check("bp_ready", bus.ready, 0);
        end
        bus.start = 1'b0;
        handshake(1'b1);

        // Async reset in mid-LOAD, then a clean frame
        tick();
        start_frame();
        feed(300, 1'b0, 0, -1);
        rst = 1'b1;
        exp_q.delete();
        res_q.delete();
        #1;
        check_reset_outputs("midload_reset");
        tick();
        rst = 1'b0;
        tick();
        start_frame();
        feed(NPIX, 1'b0, 0, -1);
        drain("frame3_drain");
        give_result(4'd2, 4'd2);
        handshake(1'b0);

`ifdef CNN_SEQ_TIMEOUT_EN
        // Watchdog forces a result when the classifier stays silent
        begin
            res_t r;
            int   k = 0;
            start_frame();
            feed(NPIX, 1'b0, 0, -1);
            drain("frame4_drain");
            r.pred = 4'hF;
            r.tmo  = 1'b1;
            res_q.push_back(r);
            while (!bus.valid_out && k < 40) begin
                tick();
                k++;
            end
            check("timeout_valid_out", bus.valid_out, 1);
            check("timeout_prediction", bus.prediction, 4'hF);
            check("timeout_err_set", bus.timeout_err, 1);
            handshake(1'b0);
        end
`endif

        tick();
        check("results_consumed", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
